// File: rtl/param_alu_pkg.sv
// rtl/param_alu_pkg.sv - shared opcodes, FSM encoding and default width for param_alu
// Purpose: constants shared by param_alu and alu_divider.
//   DEFAULT_WIDTH : default operand/result width
//   alu_op_e      : 3-bit opcode encoding (111 reserved, behaves as clear)
//   alu_state_e   : control FSM states (IDLE, DIV_RUN)
package param_alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_MUL = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_DIV = 3'b100,
    OP_MAC = 3'b101,
    OP_CLR = 3'b110,
    OP_RSV = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DIV_RUN = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring divider, one quotient bit per cycle
// Purpose: unsigned WIDTH-bit division over WIDTH iterations after a load.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (aborts a running division)
//   i_start     : load dividend/divisor; iterations begin on the following edge
//   i_dividend  : dividend, captured on i_start
//   i_divisor   : divisor (non-zero), captured on i_start
//   o_done      : high during the cycle whose edge performs the last iteration
//   o_quotient  : quotient produced by the current iteration (final when o_done)
module alu_divider
  import param_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_active;

  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Shift the next dividend bit into the partial remainder. The shifted value
  // can reach WIDTH+1 bits, but once the divisor fits the difference is below
  // the divisor, so a WIDTH-bit modular subtract is exact.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_fits     = (w_shift >= {1'b0, r_div});
  assign w_rem_next = w_fits ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  assign o_done     = r_active && (r_cnt == CW'(WIDTH - 1));
  assign o_quotient = w_quo_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_div    <= i_divisor;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (o_done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_alu.sv
// rtl/param_alu.sv - parameterised registered ALU with accumulator and iterative divide
// Purpose: single-issue ALU; one-cycle ops plus a WIDTH-cycle divide.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   in1, in2     : unsigned operands, captured on the accepting edge
//   alu_control  : opcode (see alu_op_e)
//   start        : request, accepted only while busy=0
//   busy         : divide in progress
//   out          : registered result / accumulator
//   zflag        : out == 0 (combinational)
//   dz_flag      : last completed op was divide by zero
//   ac_load      : one-cycle completion strobe, out valid in the same cycle
module param_alu
  import param_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_control,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             zflag,
  output logic             dz_flag,
  output logic             ac_load
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  alu_op_e          w_op;
  logic             w_accept;
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quotient;
  logic [WIDTH-1:0] w_prod;

  assign w_op        = alu_op_e'(alu_control);
  assign busy        = (r_state == ST_DIV_RUN);
  assign w_accept    = start && !busy;
  assign w_div_start = w_accept && (w_op == OP_DIV) && (in2 != '0);
  assign w_prod      = in1 * in2;
  assign zflag       = (out == '0);

  alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (in1),
    .i_divisor  (in2),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_div_start) w_state_next = ST_DIV_RUN;
      ST_DIV_RUN: if (w_div_done)  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= '0;
      dz_flag <= 1'b0;
      ac_load <= 1'b0;
    end else begin
      ac_load <= 1'b0;
      if (w_div_done) begin
        out     <= w_quotient;
        ac_load <= 1'b1;
      end else if (w_accept && (w_op != OP_NOP)) begin
        dz_flag <= 1'b0;
        ac_load <= 1'b1;
        case (w_op)
          OP_MUL: out <= w_prod;
          OP_ADD: out <= in1 + in2;
          OP_SUB: out <= in1 - in2;
          OP_MAC: out <= out + w_prod;
          OP_DIV: begin
            // Non-zero divisor: out holds and the strobe comes from the divider.
            if (in2 == '0) begin
              out     <= '1;
              dz_flag <= 1'b1;
            end else begin
              ac_load <= 1'b0;
            end
          end
          default: out <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// tb/tb_param_alu.sv - self-checking bench for param_alu against an arithmetic reference model
module tb_param_alu;

  localparam int W = 16;
  localparam longint MOD = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1, in2;
  logic [2:0]   alu_control;
  logic         start;
  logic         busy;
  logic [W-1:0] out;
  logic         zflag;
  logic         dz_flag;
  logic         ac_load;

  int n_total = 0;
  int n_bad   = 0;

  longint m_out = 0;
  bit     m_dz  = 1'b0;

  param_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in1         (in1),
    .in2         (in2),
    .alu_control (alu_control),
    .start       (start),
    .busy        (busy),
    .out         (out),
    .zflag       (zflag),
    .dz_flag     (dz_flag),
    .ac_load     (ac_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result and strobe of one accepted op from its arithmetic meaning.
  task automatic issue(input logic [2:0] op, input longint a, input longint b, input bit poke);
    longint prev;
    longint res;
    bit     strobe;
    bit     iter;
    prev   = m_out;
    strobe = 1'b1;
    iter   = 1'b0;
    case (op)
      3'b000: begin res = m_out; strobe = 1'b0; end
      3'b001: res = (a * b) % MOD;
      3'b010: res = (a + b) % MOD;
      3'b011: res = (a + MOD - b) % MOD;
      3'b100: begin
        if (b == 0) res = MOD - 1;
        else begin res = a / b; iter = 1'b1; end
      end
      3'b101: res = (m_out + a * b) % MOD;
      default: res = 0;
    endcase
    alu_control = op;
    in1 = W'(a);
    in2 = W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
    alu_control = 3'($urandom);
    if (iter) begin
      for (int c = 1; c <= W; c++) begin
        check("div_busy", 32'(busy), 32'd1);
        check("div_hold", 32'(out), 32'(prev));
        check("div_noload", 32'(ac_load), 32'd0);
        if (poke) begin
          start = 1'($urandom_range(0, 1));
          alu_control = 3'b010;
          in1 = W'($urandom);
          in2 = W'($urandom);
        end
        tick();
      end
      start = 1'b0;
    end
    m_out = res;
    if (op != 3'b000) m_dz = (op == 3'b100) && (b == 0);
    check("out", 32'(out), 32'(m_out));
    check("ac_load", 32'(ac_load), 32'(strobe));
    check("busy_end", 32'(busy), 32'd0);
    check("zflag", 32'(zflag), 32'(m_out == 0));
    check("dz_flag", 32'(dz_flag), 32'(m_dz));
  endtask

  task automatic idle_check();
    tick();
    check("strobe_single", 32'(ac_load), 32'd0);
    check("idle_hold", 32'(out), 32'(m_out));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    alu_control = 3'b010;
    in1 = 16'h0011;
    in2 = 16'h0022;
    tick();
    tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ac_load", 32'(ac_load), 32'd0);
    check("rst_dz", 32'(dz_flag), 32'd0);
    check("rst_zflag", 32'(zflag), 32'd1);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    issue(3'b010, 'hFFFF, 'h0002, 1'b0); idle_check();
    issue(3'b011, 'h0005, 'h0005, 1'b0); idle_check();
    issue(3'b011, 'h0003, 'h0005, 1'b0); idle_check();
    issue(3'b110, 'h1234, 'h5678, 1'b0);
    issue(3'b101, 3, 4, 1'b0);
    issue(3'b101, 'h0100, 'h0100, 1'b0); idle_check();
    issue(3'b000, 'h00FF, 'h0001, 1'b0); idle_check();
    issue(3'b100, 1000, 7, 1'b1); idle_check();
    issue(3'b100, 'h1234, 0, 1'b0);
    issue(3'b010, 1, 1, 1'b0); idle_check();
    issue(3'b111, 'hABCD, 'h0001, 1'b0); idle_check();
    issue(3'b100, 'hFFFF, 1, 1'b0);
    issue(3'b100, 5, 'hFFFF, 1'b0); idle_check();

    // Reset during a division, with a concurrent start that must be ignored.
    alu_control = 3'b100;
    in1 = 16'd1000;
    in2 = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    alu_control = 3'b010;
    in1 = 16'd9;
    in2 = 16'd9;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    m_out = 0;
    m_dz = 1'b0;
    check("abort_out", 32'(out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ac_load", 32'(ac_load), 32'd0);
    for (int c = 0; c < W + 2; c++) begin
      tick();
      check("abort_no_strobe", 32'(ac_load), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    issue(3'b001, 6, 7, 1'b0); idle_check();

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      longint a;
      longint b;
      op = 3'($urandom_range(0, 7));
      a = longint'($urandom_range(0, 65535));
      b = longint'($urandom_range(0, 65535));
      if (op == 3'b100 && $urandom_range(0, 4) == 0) b = 0;
      if (op == 3'b100 && $urandom_range(0, 2) == 0) b = longint'($urandom_range(1, 40));
      issue(op, a, b, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
